csr_access_arbiter: RTL and testbench
=====================================

Name: csr_access_arbiter

Overview:
Owns the CSR register file: tohost (0x51e) plus read-only counters cycle (0xC00) and instret (0xC02). Shares the single CSR read-modify-write port between two requesters: the core EX stage (decoded CSR instructions) and a host/debug port (UART-driven). It sequences each access through an IDLE→ACCESS→RESP state machine and arbitrates with core priority plus a host anti-starvation timer.

Parameters:
HOST_MAX_WAIT, 8, cycles the host may wait with valid high before it wins arbitration over the core
TOHOST_ADDR, 12'h51e, address of the tohost CSR

Ports:
clk  input  1  core clock
rst_n  input  1  reset, active-low
core_req_valid  input  1  core CSR request
core_req_ready  output  1  core request accepted when valid&ready
core_inst  input  32  CSR instruction (opcode 0x73)
core_rs1_data  input  32  rs1 operand
core_rvalid  output  1  one-cycle pulse: core_rdata valid
core_rdata  output  32  old CSR value, written back to rd
host_req_valid  input  1  host request
host_req_ready  output  1  host request accepted when valid&ready
host_addr  input  12  CSR address
host_we  input  1  1 = write host_wdata, 0 = read only
host_wdata  input  32  host write data
host_rvalid  output  1  one-cycle pulse: host_rdata valid
host_rdata  output  32  old CSR value
instret_inc  input  1  retire pulse: increments instret
tohost  output  32  current tohost value
access_err  output  1  one-cycle pulse: unmapped address or write to read-only CSR

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low. Sampled low at a clk edge: state=IDLE, tohost=0, cycle=0, instret=0, wait_cnt=0, all rvalid/rdata/access_err=0. Both ready outputs are forced 0 while rst_n is low.
- Reset mid-operation: any in-flight request is dropped, with no rvalid and no write.
- Core decode: csr=inst[31:20]; funct3=inst[14:12] with 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI. Operand is rs1_data, or zimm=inst[19:15] zero-extended for the I-forms.
- Core writes: RS gives old|op, RC gives old&~op, RW/RWI give op. RS/RC/RSI/RCI with inst[19:15]==0 perform no write and no err.
- Host access: host_we=1 behaves as RW; host_we=0 behaves as a read with no write.
- Grant: ready is high only in IDLE, and only to the granted requester. Core wins a tie unless wait_cnt>=HOST_MAX_WAIT, in which case host wins.
- wait_cnt: increments, saturating, each cycle host_req_valid is high and host is not granted. Cleared on host accept.
- IDLE→ACCESS on accept: latch requester id, address, op and operand.
- ACCESS: read the old value; at the end-of-cycle edge, commit the write and register rdata and access_err. Then go to RESP.
- RESP: the selected rvalid is high for exactly this cycle. Then go to IDLE.
- Latency and throughput: accept at edge N, rvalid high in the cycle after edge N+1. One access per 3 cycles.
- Read-only/unmapped: a write to 0xC00/0xC02 is ignored with access_err=1. Unmapped address returns rdata=0, access_err=1, no write.
- Counters: cycle +1 every non-reset cycle; instret +1 when instret_inc=1. Both wrap 0xFFFFFFFF→0. A read returns the pre-increment value sampled in ACCESS.
- tohost: updates only at the ACCESS commit edge; an RMW uses the value in that same cycle.

Optional Feature:
CSR_ARB_COUNTERS_EN
- Defined: cycle/instret counters exist as specified.
- Undefined: counters are not instantiated, instret_inc is ignored, 0xC00/0xC02 read 0 with access_err=0, and writes to them are ignored with access_err=1.

Test Plan:
- Reset then core 0x51e51073, rs1=1: tohost=1, core_rdata=0, rvalid 2 cycles after accept. Then 0x51e0d073 (zimm=1): rdata=1, tohost=1.
- tohost=1, core 0x51e52073 rs1=4 → tohost=5, rdata=1. Then 0x51e53073 rs1=1 → tohost=4, rdata=5. Then 0x51e52073 with rs1 field 0 → no write, tohost=4.
- Core and host both valid with HOST_MAX_WAIT=8 and core held valid → core granted until host has waited 8 cycles, then host granted; wait_cnt clears.
- Host write addr 0x51e data 0xA → tohost=0xA, host_rdata=old. Host write 0xC00 → access_err pulse, cycle unchanged. Host read 0x123 → rdata=0, access_err=1.
- Core 0xC0002073 after 20 cycles out of reset → rdata equals the cycle count at ACCESS. With the macro undefined → rdata=0, access_err=0.
- rst_n low during ACCESS of a tohost write of 0x7 → no rvalid, tohost=0, state IDLE, ready re-asserts the cycle after rst_n returns high.

Source files
------------

// File: rtl/csr_access_arbiter_if.sv
// CSR access bus: core EX-stage and host/debug request/response channels.
// Requesters sit on the master modport; the CSR arbiter is the slave.
interface csr_access_arbiter_if;
   logic        core_req_valid;
   logic        core_req_ready;
   logic [31:0] core_inst;
   logic [31:0] core_rs1_data;
   logic        core_rvalid;
   logic [31:0] core_rdata;
   logic        host_req_valid;
   logic        host_req_ready;
   logic [11:0] host_addr;
   logic        host_we;
   logic [31:0] host_wdata;
   logic        host_rvalid;
   logic [31:0] host_rdata;

   modport master (
      output core_req_valid, core_inst, core_rs1_data,
      input  core_req_ready, core_rvalid, core_rdata,
      output host_req_valid, host_addr, host_we, host_wdata,
      input  host_req_ready, host_rvalid, host_rdata
   );

   modport slave (
      input  core_req_valid, core_inst, core_rs1_data,
      output core_req_ready, core_rvalid, core_rdata,
      input  host_req_valid, host_addr, host_we, host_wdata,
      output host_req_ready, host_rvalid, host_rdata
   );
endinterface

// File: rtl/csr_access_arbiter.sv
// CSR file (tohost, cycle, instret) shared by core and host over one RMW port; counters under CSR_ARB_COUNTERS_EN.
// Latency: accept at edge N, rvalid pulse in the cycle after edge N+1; one access per 3 cycles.
// Backpressure: ready only in IDLE to the granted side; core wins ties until the host has waited HOST_MAX_WAIT cycles.
module csr_access_arbiter #(
   parameter int          HOST_MAX_WAIT = 8,
   parameter logic [11:0] TOHOST_ADDR   = 12'h51e
) (
   input  logic                  clk,
   input  logic                  rst_n,
   csr_access_arbiter_if.slave   bus,
   input  logic                  instret_inc,
   output logic [31:0]           tohost,
   output logic                  access_err
);

   localparam int WCNT_W = ($clog2(HOST_MAX_WAIT + 1) < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(HOST_MAX_WAIT);
   localparam logic [11:0] CYCLE_ADDR   = 12'hC00;
   localparam logic [11:0] INSTRET_ADDR = 12'hC02;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
   typedef enum logic [1:0] {OP_READ, OP_RW, OP_RS, OP_RC} op_t;

   state_t            r_state, w_state_nxt;
   logic              r_id_host;
   logic [11:0]       r_addr;
   op_t               r_op;
   logic [31:0]       r_operand;
   logic              r_wr_en;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic [31:0]       r_tohost;
   logic [31:0]       r_core_rdata, r_host_rdata;
   logic              r_core_rvalid, r_host_rvalid, r_access_err;

   logic [2:0]  w_funct3;
   logic [4:0]  w_zimm;
   op_t         w_core_op;
   logic [31:0] w_core_operand;
   logic        w_core_wr;
   logic        w_idle, w_host_win, w_core_acc, w_host_acc;
   logic        w_is_tohost, w_is_ro, w_err, w_commit;
   logic [31:0] w_old, w_new;

`ifdef CSR_ARB_COUNTERS_EN
   logic [31:0] r_cycle, r_instret;
   logic [4:0]  w_unused_bits;
   assign w_unused_bits = bus.core_inst[11:7];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (instret_inc) r_instret <= r_instret + 32'd1;
      end
   end
`else
   logic [5:0] w_unused_bits;
   assign w_unused_bits = {bus.core_inst[11:7], instret_inc};
`endif

   // Core decode: I-forms take zimm as operand; set/clear with a zero rs1/zimm field never write.
   always_comb begin
      w_funct3       = bus.core_inst[14:12];
      w_zimm         = bus.core_inst[19:15];
      w_core_op      = OP_READ;
      w_core_operand = w_funct3[2] ? {27'd0, w_zimm} : bus.core_rs1_data;
      if (bus.core_inst[6:0] == 7'h73) begin
         case (w_funct3[1:0])
            2'b01:   w_core_op = OP_RW;
            2'b10:   w_core_op = OP_RS;
            2'b11:   w_core_op = OP_RC;
            default: w_core_op = OP_READ;
         endcase
      end
      w_core_wr = (w_core_op == OP_RW) ||
                  (((w_core_op == OP_RS) || (w_core_op == OP_RC)) && (w_zimm != 5'd0));
   end

   assign w_idle     = (r_state == S_IDLE);
   assign w_host_win = bus.host_req_valid && (!bus.core_req_valid || (r_wait_cnt >= WAIT_MAX));
   assign bus.core_req_ready = rst_n && w_idle && !w_host_win;
   assign bus.host_req_ready = rst_n && w_idle &&  w_host_win;
   assign w_core_acc = bus.core_req_valid && bus.core_req_ready;
   assign w_host_acc = bus.host_req_valid && bus.host_req_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_core_acc || w_host_acc) w_state_nxt = S_ACCESS;
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_is_tohost = (r_addr == TOHOST_ADDR);
      w_is_ro     = (r_addr == CYCLE_ADDR) || (r_addr == INSTRET_ADDR);
      w_old       = '0;
      if (w_is_tohost) w_old = r_tohost;
`ifdef CSR_ARB_COUNTERS_EN
      else if (r_addr == CYCLE_ADDR)   w_old = r_cycle;
      else if (r_addr == INSTRET_ADDR) w_old = r_instret;
`endif
      case (r_op)
         OP_RW:   w_new = r_operand;
         OP_RS:   w_new = w_old | r_operand;
         OP_RC:   w_new = w_old & ~r_operand;
         default: w_new = w_old;
      endcase
      w_err    = (!w_is_tohost && !w_is_ro) || (r_wr_en && w_is_ro);
      w_commit = (r_state == S_ACCESS) && r_wr_en && w_is_tohost;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_id_host     <= 1'b0;
         r_addr        <= '0;
         r_op          <= OP_READ;
         r_operand     <= '0;
         r_wr_en       <= 1'b0;
         r_wait_cnt    <= '0;
         r_tohost      <= '0;
         r_core_rdata  <= '0;
         r_host_rdata  <= '0;
         r_core_rvalid <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_access_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_host_acc) begin
            r_id_host <= 1'b1;
            r_addr    <= bus.host_addr;
            r_op      <= bus.host_we ? OP_RW : OP_READ;
            r_operand <= bus.host_wdata;
            r_wr_en   <= bus.host_we;
         end else if (w_core_acc) begin
            r_id_host <= 1'b0;
            r_addr    <= bus.core_inst[31:20];
            r_op      <= w_core_op;
            r_operand <= w_core_operand;
            r_wr_en   <= w_core_wr;
         end
         if (w_host_acc)
            r_wait_cnt <= '0;
         else if (bus.host_req_valid && (r_wait_cnt != WAIT_MAX))
            r_wait_cnt <= r_wait_cnt + 1'b1;
         r_core_rvalid <= (r_state == S_ACCESS) && !r_id_host;
         r_host_rvalid <= (r_state == S_ACCESS) &&  r_id_host;
         r_access_err  <= (r_state == S_ACCESS) && w_err;
         if (r_state == S_ACCESS) begin
            if (r_id_host) r_host_rdata <= w_old;
            else           r_core_rdata <= w_old;
         end
         if (w_commit) r_tohost <= w_new;
      end
   end

   assign bus.core_rvalid = r_core_rvalid;
   assign bus.core_rdata  = r_core_rdata;
   assign bus.host_rvalid = r_host_rvalid;
   assign bus.host_rdata  = r_host_rdata;
   assign tohost          = r_tohost;
   assign access_err      = r_access_err;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: vector table of single accesses plus
// arbitration, counter and mid-access reset sequences.
module tb_csr_access_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instret_inc = 1'b0;
   logic [31:0] tohost;
   logic        access_err;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_cycle = '0;
   logic [31:0] m_instret = '0;

   csr_access_arbiter_if bus();

   csr_access_arbiter #(.HOST_MAX_WAIT(8), .TOHOST_ADDR(12'h51e)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .instret_inc(instret_inc),
      .tohost(tohost), .access_err(access_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cycle   <= '0;
         m_instret <= '0;
      end else begin
         m_cycle <= m_cycle + 32'd1;
         if (instret_inc) m_instret <= m_instret + 32'd1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        is_host;
      logic [31:0] inst;
      logic [31:0] rs1;
      logic [11:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] exp_toh;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge, wait for grant, then wait for its rvalid.
   task automatic txn(input logic is_host, input logic [31:0] inst, input logic [31:0] rs1,
                      input logic [11:0] addr, input logic we, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic other_rv, output logic [31:0] cyc_snap);
      int guard;
      rdata = '0; err = 1'b0; lat = 99; other_rv = 1'b0; cyc_snap = '0;
      if (is_host) begin
         bus.host_req_valid = 1'b1; bus.host_addr = addr; bus.host_we = we; bus.host_wdata = wdata;
      end else begin
         bus.core_req_valid = 1'b1; bus.core_inst = inst; bus.core_rs1_data = rs1;
      end
      #1;
      guard = 0;
      while (!(is_host ? bus.host_req_ready : bus.core_req_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         chk("grant_timeout", 32'd0, 32'd1);
         bus.host_req_valid = 1'b0; bus.core_req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cyc_snap = m_cycle;
      bus.host_req_valid = 1'b0; bus.core_req_valid = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (is_host ? bus.host_rvalid : bus.core_rvalid) begin
            lat      = n;
            rdata    = is_host ? bus.host_rdata : bus.core_rdata;
            err      = access_err;
            other_rv = is_host ? bus.core_rvalid : bus.host_rvalid;
            break;
         end
      end
   endtask

   vec_t        vecs[13];
   logic [31:0] rd, snap;
   logic        er, orv, bad;
   int          lat, core_grants, host_idx, next_core_idx;

   initial begin
      vecs[0]  = '{1'b0, 32'h51e51073, 32'd1,    12'h000, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0, 32'h1};
      vecs[1]  = '{1'b0, 32'h51e0d073, 32'd0,    12'h000, 1'b0, 32'h0,  1'b1, 32'h1, 1'b0, 32'h1};
      vecs[2]  = '{1'b0, 32'h51e52073, 32'd4,    12'h000, 1'b0, 32'h0,  1'b1, 32'h1, 1'b0, 32'h5};
      vecs[3]  = '{1'b0, 32'h51e53073, 32'd1,    12'h000, 1'b0, 32'h0,  1'b1, 32'h5, 1'b0, 32'h4};
      vecs[4]  = '{1'b0, 32'h51e02073, 32'hFF,   12'h000, 1'b0, 32'h0,  1'b1, 32'h4, 1'b0, 32'h4};
      vecs[5]  = '{1'b1, 32'h0,        32'd0,    12'h51e, 1'b1, 32'hA,  1'b1, 32'h4, 1'b0, 32'hA};
      vecs[6]  = '{1'b1, 32'h0,        32'd0,    12'hC00, 1'b1, 32'h55, 1'b0, 32'h0, 1'b1, 32'hA};
      vecs[7]  = '{1'b1, 32'h0,        32'd0,    12'h123, 1'b0, 32'h0,  1'b1, 32'h0, 1'b1, 32'hA};
      vecs[8]  = '{1'b1, 32'h0,        32'd0,    12'h51e, 1'b0, 32'h0,  1'b1, 32'hA, 1'b0, 32'hA};
      vecs[9]  = '{1'b0, 32'h51e1f073, 32'd0,    12'h000, 1'b0, 32'h0,  1'b1, 32'hA, 1'b0, 32'h8};
      vecs[10] = '{1'b0, 32'h51e3e073, 32'd0,    12'h000, 1'b0, 32'h0,  1'b1, 32'h8, 1'b0, 32'hF};
      vecs[11] = '{1'b0, 32'hC0251073, 32'd9,    12'h000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'hF};
      vecs[12] = '{1'b0, 32'h12351073, 32'd3,    12'h000, 1'b0, 32'h0,  1'b1, 32'h0, 1'b1, 32'hF};

      // Reset with both requesters valid: readies must stay low.
      bus.core_req_valid = 1'b1; bus.core_inst = 32'h51e51073; bus.core_rs1_data = 32'd1;
      bus.host_req_valid = 1'b1; bus.host_addr = 12'h51e; bus.host_we = 1'b1; bus.host_wdata = 32'h3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_core_ready", {31'd0, bus.core_req_ready}, 32'd0);
      chk("rst_host_ready", {31'd0, bus.host_req_ready}, 32'd0);
      chk("rst_tohost", tohost, 32'd0);
      chk("rst_rvalid_err", {29'd0, bus.core_rvalid, bus.host_rvalid, access_err}, 32'd0);
      chk("rst_rdata", bus.core_rdata | bus.host_rdata, 32'd0);
      bus.core_req_valid = 1'b0; bus.host_req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         txn(vecs[i].is_host, vecs[i].inst, vecs[i].rs1, vecs[i].addr, vecs[i].we,
             vecs[i].wdata, rd, er, lat, orv, snap);
         chk($sformatf("v%0d_latency", i), lat, 32'd2);
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_tohost", i), tohost, vecs[i].exp_toh);
         chk($sformatf("v%0d_other_rvalid", i), {31'd0, orv}, 32'd0);
      end

      // Arbitration: both held valid from IDLE; host wins after waiting out the core.
      @(negedge clk);
      bus.core_req_valid = 1'b1; bus.core_inst = 32'h51e02073; bus.core_rs1_data = 32'd0;
      bus.host_req_valid = 1'b1; bus.host_addr = 12'h51e; bus.host_we = 1'b0;
      #1;
      core_grants = 0; host_idx = -1; next_core_idx = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.host_req_ready) begin host_idx = i; break; end
         if (bus.core_req_ready) core_grants++;
         @(negedge clk);
      end
      if (host_idx >= 0) begin
         for (int j = host_idx + 1; j < host_idx + 20; j++) begin
            @(negedge clk);
            if (bus.core_req_ready || bus.host_req_ready) begin
               next_core_idx = bus.core_req_ready ? j : -2;
               break;
            end
         end
      end
      @(posedge clk);
      #1;
      bus.core_req_valid = 1'b0; bus.host_req_valid = 1'b0;
      chk("arb_core_grants_before_host", core_grants, 32'd3);
      chk("arb_host_grant_cycle", host_idx, 32'd9);
      chk("arb_core_after_host_clear", next_core_idx, 32'd12);
      repeat (3) @(negedge clk);

      // Counters: cycle read after 20 cycles, instret after 5 retire pulses.
      repeat (20) @(negedge clk);
      txn(1'b0, 32'hC0002073, 32'd0, 12'h000, 1'b0, 32'h0, rd, er, lat, orv, snap);
`ifdef CSR_ARB_COUNTERS_EN
      chk("cycle_rdata", rd, snap);
`else
      chk("cycle_rdata", rd, 32'd0);
`endif
      chk("cycle_err", {31'd0, er}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         instret_inc = 1'b1;
         @(negedge clk);
      end
      instret_inc = 1'b0;
      txn(1'b1, 32'h0, 32'd0, 12'hC02, 1'b0, 32'h0, rd, er, lat, orv, snap);
`ifdef CSR_ARB_COUNTERS_EN
      chk("instret_rdata", rd, 32'd5);
`else
      chk("instret_rdata", rd, 32'd0);
`endif
      chk("instret_err", {31'd0, er}, 32'd0);

      // Reset during ACCESS of a host tohost write of 7.
      @(negedge clk);
      bus.host_req_valid = 1'b1; bus.host_addr = 12'h51e; bus.host_we = 1'b1; bus.host_wdata = 32'h7;
      #1;
      chk("midrst_pre_grant", {31'd0, bus.host_req_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.host_req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
      chk("midrst_ready_low", {30'd0, bus.core_req_ready, bus.host_req_ready}, 32'd0);
      chk("midrst_tohost", tohost, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_back", {31'd0, bus.core_req_ready}, 32'd1);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.host_rvalid || bus.core_rvalid || tohost != 32'd0) bad = 1'b1;
      end
      chk("midrst_no_late_effect", {31'd0, bad}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
